regfile_dumper: RTL and testbench

Debug read-out engine for the 32×32 register file: on a start pulse it drives one register-file read-address port, walking the registers in ascending order, and streams each register's contents with its index over a valid/ready output. It connects to the register file's asynchronous read port (`ra1`/`rd1`) and to a debug host or trace sink on the output side. It is the read side of the register file's write-then-read interface, so register state can be verified or exported without touching the core datapath.

---
 rtl/regfile_dumper.sv | 86 ++++++++
 tb/tb_regfile_dumper.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_dumper.sv
// regfile_dumper: debug read-out engine for a register file.
// On a start pulse it walks the register file's asynchronous read port in
// ascending index order and streams {index, value} beats over valid/ready.
// A done pulse follows acceptance of the final beat.
// Optional build macro: REGDUMP_SKIP_X0_EN -- when defined the walk starts
// at index 1 (x0 is skipped); ports are identical in both builds.
module regfile_dumper #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
`ifdef REGDUMP_SKIP_X0_EN
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
`else
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = '0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  state_t state;

  // Walk FSM: FETCH samples the read port, SEND holds the beat until the
  // sink takes it, then either steps the address or finishes. The address
  // stops at the last index, so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ra        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= FIRST_IDX;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          out_data  <= rd;
          out_idx   <= ra;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (ra == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ra    <= ra + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          // start seen here is dropped, not queued
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: directed bench for regfile_dumper. The bench owns a
// 32x32 register-file model that answers the read port combinationally.
module tb_regfile_dumper;
  localparam int NR = 32;
`ifdef REGDUMP_SKIP_X0_EN
  localparam int FIRST = 1;
  localparam int FULL_EDGES = 63;
`else
  localparam int FIRST = 0;
  localparam int FULL_EDGES = 65;
`endif

  logic        clk, reset, start, busy, out_valid, out_ready, done;
  logic [4:0]  ra, out_idx;
  logic [31:0] rd, out_data;
  logic [31:0] rf [NR];

  int n_tests = 0;
  int n_fail  = 0;
  int edges;
  int k;

  regfile_dumper #(.NUM_REGS(NR), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .ra(ra), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .done(done)
  );

  assign rd = rf[ra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-computed register contents.
  function automatic logic [31:0] expv(input int i);
    case (i)
      0: return 32'h0000_0000;
      1: return 32'hAAAA_AAAA;
      2: return 32'h1234_5678;
      3: return 32'hDEAD_BEEF;
      default: return 32'(i) * 32'h0101_0101;
    endcase
  endfunction

  // One full dump. Called at a falling edge with the DUT idle. edges_out is
  // the number of rising edges from the start-sampling edge (counted as 1)
  // through the edge that raises done, i.e. the cycle in which done is seen.
  task automatic dump(input int stall_idx, input int stall_n, input int poke_idx,
                      input bit poke_done, output int edges_out);
    int  exp_idx, nbeats, stalled, cur;
    bit  poked, seen_done;
    exp_idx = FIRST; nbeats = 0; stalled = 0; poked = 0; seen_done = 0;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; edges_out = 1;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("ra_first", 64'(ra), 64'(FIRST));
    chk("valid_after_start", 64'(out_valid), 64'(0));
    while (!seen_done && edges_out < 400) begin
      start = 1'b0; out_ready = 1'b1;
      if (done) begin
        seen_done = 1'b1;
        chk("beat_count", 64'(nbeats), 64'(NR - FIRST));
        chk("busy_in_done", 64'(busy), 64'(0));
        chk("ra_last", 64'(ra), 64'(NR - 1));
        if (poke_done) start = 1'b1;
      end else begin
        chk("busy_mid", 64'(busy), 64'(1));
        if (out_valid) begin
          cur = exp_idx;
          chk("out_idx", 64'(out_idx), 64'(cur));
          chk("out_data", 64'(out_data), 64'(expv(cur)));
          chk("ra_hold", 64'(ra), 64'(cur));
          if (cur == poke_idx && !poked) begin
            start = 1'b1; poked = 1'b1;
          end
          if (cur == stall_idx && stalled < stall_n) begin
            out_ready = 1'b0; stalled++;
          end else begin
            exp_idx++; nbeats++;
          end
        end
        @(negedge clk);
        edges_out++;
      end
    end
    if (!seen_done) chk("dump_timeout", 64'(0), 64'(1));
    @(negedge clk);
    start = 1'b0;
    chk("done_single", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_valid", 64'(out_valid), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf[i] = expv(i);
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ra", 64'(ra), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_idx", 64'(out_idx), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy0", 64'(busy), 64'(0));
    chk("idle_valid0", 64'(out_valid), 64'(0));
    chk("idle_ra0", 64'(ra), 64'(0));

    // Constant ready.
    dump(-1, 0, -1, 1'b0, edges);
    chk("full_latency", 64'(edges), 64'(FULL_EDGES));

    // Five stall cycles on idx 2.
    dump(2, 5, -1, 1'b0, edges);
    chk("stall_latency", 64'(edges), 64'(FULL_EDGES + 5));

    // start during SEND of idx 10 and during DONE: both ignored.
    dump(-1, 0, 10, 1'b1, edges);
    chk("poke_latency", 64'(edges), 64'(FULL_EDGES));

    // Immediately following dump starts fresh at the first index.
    dump(-1, 0, -1, 1'b0, edges);
    chk("back2back_latency", 64'(edges), 64'(FULL_EDGES));

    // Reset in the middle of a dump, while beat idx 7 is presented.
    start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(out_valid && out_idx == 5'd7) && k < 100) begin
      out_ready = 1'b1;
      if (out_valid && out_idx == 5'd6) begin
        @(negedge clk); out_ready = 1'b0;
      end else @(negedge clk);
      k++;
    end
    chk("reach_idx7", 64'(out_valid && out_idx == 5'd7), 64'(1));
    chk("idx7_data", 64'(out_data), 64'(expv(7)));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ra", 64'(ra), 64'(0));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_data", 64'(out_data), 64'(0));
    chk("mid_rst_idx", 64'(out_idx), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 64'(done), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(0));
    end
    dump(-1, 0, -1, 1'b0, edges);
    chk("after_rst_latency", 64'(edges), 64'(FULL_EDGES));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
